// File: rtl/pdua_pkg.sv
// Shared definitions for the PDUA control unit: ALU codes, opcodes, FSM states
// and the opcode classifier used by the sequencer.
package pdua_pkg;

    localparam logic [2:0] SEL_PASSB = 3'b000;
    localparam logic [2:0] SEL_ADD   = 3'b001;
    localparam logic [2:0] SEL_INCB  = 3'b010;
    localparam logic [2:0] SEL_AND   = 3'b011;
    localparam logic [2:0] SEL_NOT   = 3'b100;

    localparam int unsigned OPC_NOP    = 32'h00;
    localparam int unsigned OPC_MOV_LD = 32'h01;
    localparam int unsigned OPC_MOV_ST = 32'h02;
    localparam int unsigned OPC_ADD    = 32'h03;
    localparam int unsigned OPC_JZ     = 32'h04;
    localparam int unsigned OPC_HALT   = 32'h1F;

    typedef enum logic [3:0] {
        INIT,
        F_MAR,
        F_MEM,
        F_IR,
        F_PC,
        E1,
        E2,
        E3,
        HALT
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_LOAD,
        OP_STORE,
        OP_ADD,
        OP_JZ,
        OP_HALT,
        OP_ILLEGAL
    } op_kind_e;

    function automatic op_kind_e decode_op(input int unsigned opc);
        op_kind_e kind;
        case (opc)
            OPC_NOP:    kind = OP_NOP;
            OPC_MOV_LD: kind = OP_LOAD;
            OPC_MOV_ST: kind = OP_STORE;
            OPC_ADD:    kind = OP_ADD;
            OPC_JZ:     kind = OP_JZ;
            OPC_HALT:   kind = OP_HALT;
            default:    kind = OP_ILLEGAL;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/pdua_control_unit.sv
// Multi-cycle microsequencer producing the PDUA datapath control word:
// fetch, decode, execute with memory wait states, timeout, pause and halt.
module pdua_control_unit
    import pdua_pkg::*;
#(
    parameter int MAX_WIDTH  = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int OPC_WIDTH  = 5,
    parameter int PC_ADDR    = 0,
    parameter int DPTR_ADDR  = 2,
    parameter int ACC_ADDR   = 7,
    parameter int WAIT_MAX   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic [OPC_WIDTH-1:0]  out_IR,
    input  logic                  C,
    input  logic                  N,
    input  logic                  P,
    input  logic                  Z,
    input  logic                  mem_ready,
    output logic                  wr_rdn,
    output logic                  enaf,
    output logic [2:0]            selop,
    output logic [1:0]            shamt,
    output logic                  bank_wr_en,
    output logic [ADDR_WIDTH-1:0] BusB_addr,
    output logic [ADDR_WIDTH-1:0] BusC_addr,
    output logic                  sclr,
    output logic                  ir_en,
    output logic                  mar_en,
    output logic                  mdr_en,
    output logic                  mdr_alu_n,
    output logic                  halted,
    output logic                  illegal_op,
    output logic                  bus_err,
    output logic                  instr_done
);

    localparam int WCNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] PC_A   = ADDR_WIDTH'(PC_ADDR);
    localparam logic [ADDR_WIDTH-1:0] DPTR_A = ADDR_WIDTH'(DPTR_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ACC_A  = ADDR_WIDTH'(ACC_ADDR);

    if (MAX_WIDTH < 1 || OPC_WIDTH < 5 || PC_ADDR >= (1 << ADDR_WIDTH) ||
        DPTR_ADDR >= (1 << ADDR_WIDTH) || ACC_ADDR >= (1 << ADDR_WIDTH) ||
        WAIT_MAX < 0) begin : g_param_check
        $error("pdua_control_unit: inconsistent width or register-map parameters");
    end

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                bus_err_q, bus_err_d;
    op_kind_e            op_kind;
    logic                in_wait;
    logic                unused_flags;

    assign op_kind      = decode_op(32'(out_IR));
    assign unused_flags = ^{C, N, P};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= INIT;
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            bus_err_q  <= bus_err_d;
        end
    end

    // Wait states are the memory cycles that stall until mem_ready; a stall
    // that lasts WAIT_MAX cycles is treated as a dead bus and halts the core.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        bus_err_d  = bus_err_q;
        in_wait    = (state_q == F_MEM) ||
                     (state_q == E2 && op_kind == OP_LOAD) ||
                     (state_q == E3 && op_kind == OP_STORE);

        case (state_q)
            INIT:  state_d = F_MAR;
            F_MAR: if (run) state_d = F_MEM;
            F_MEM: if (mem_ready) state_d = F_IR;
            F_IR:  state_d = F_PC;
            F_PC:  state_d = E1;
            E1: begin
                case (op_kind)
                    OP_LOAD, OP_STORE: state_d = E2;
                    OP_HALT:           state_d = HALT;
                    default:           state_d = F_MAR;
                endcase
            end
            E2: begin
                if (op_kind != OP_LOAD || mem_ready) state_d = E3;
            end
            E3: begin
                if (op_kind != OP_STORE || mem_ready) state_d = F_MAR;
            end
            HALT:    state_d = HALT;
            default: state_d = INIT;
        endcase

        if (in_wait && !mem_ready) begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            if (WAIT_MAX != 0 && (int'(wait_cnt_q) + 1) == WAIT_MAX) begin
                state_d    = HALT;
                bus_err_d  = 1'b1;
                wait_cnt_d = '0;
            end
        end
    end

    // sclr is qualified by rst so that every output stays low while reset is held.
    always_comb begin
        wr_rdn     = 1'b0;
        enaf       = 1'b0;
        selop      = SEL_PASSB;
        shamt      = 2'b00;
        bank_wr_en = 1'b0;
        BusB_addr  = '0;
        BusC_addr  = '0;
        sclr       = 1'b0;
        ir_en      = 1'b0;
        mar_en     = 1'b0;
        mdr_en     = 1'b0;
        mdr_alu_n  = 1'b0;
        illegal_op = 1'b0;
        instr_done = 1'b0;

        case (state_q)
            INIT:  sclr = rst;
            F_MAR: begin
                if (run) begin
                    mar_en    = 1'b1;
                    BusB_addr = PC_A;
                    selop     = SEL_PASSB;
                end
            end
            F_MEM: mdr_en = 1'b1;
            F_IR:  ir_en  = 1'b1;
            F_PC: begin
                BusB_addr  = PC_A;
                BusC_addr  = PC_A;
                selop      = SEL_INCB;
                bank_wr_en = 1'b1;
            end
            E1: begin
                case (op_kind)
                    OP_LOAD, OP_STORE: begin
                        mar_en    = 1'b1;
                        BusB_addr = DPTR_A;
                        selop     = SEL_PASSB;
                    end
                    OP_ADD: begin
                        BusB_addr  = DPTR_A;
                        selop      = SEL_ADD;
                        enaf       = 1'b1;
                        BusC_addr  = ACC_A;
                        bank_wr_en = 1'b1;
                        instr_done = 1'b1;
                    end
                    OP_JZ: begin
                        if (Z) begin
                            BusB_addr  = DPTR_A;
                            selop      = SEL_PASSB;
                            BusC_addr  = PC_A;
                            bank_wr_en = 1'b1;
                        end
                        instr_done = 1'b1;
                    end
                    OP_NOP: instr_done = 1'b1;
                    OP_ILLEGAL: begin
                        illegal_op = 1'b1;
                        instr_done = 1'b1;
                    end
                    default: ;
                endcase
            end
            E2: begin
                if (op_kind == OP_LOAD) begin
                    mdr_en = 1'b1;
                end else if (op_kind == OP_STORE) begin
                    mdr_en    = 1'b1;
                    BusB_addr = ACC_A;
                    selop     = SEL_PASSB;
                end
            end
            E3: begin
                if (op_kind == OP_LOAD) begin
                    mdr_alu_n  = 1'b1;
                    BusC_addr  = ACC_A;
                    bank_wr_en = 1'b1;
                    instr_done = 1'b1;
                end else if (op_kind == OP_STORE) begin
                    wr_rdn     = 1'b1;
                    instr_done = mem_ready;
                end
            end
            default: ;
        endcase
    end

    assign halted  = (state_q == HALT);
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_pdua_control_unit.sv
// Self-checking bench for pdua_control_unit: directed vector table, abort and
// timeout sequences, then a random instruction stream against a phase model.
module tb_pdua_control_unit;

    localparam int WAIT_MAX = 15;
    localparam logic [2:0] R_PC = 3'd0, R_DPTR = 3'd2, R_ACC = 3'd7;
    localparam logic [2:0] ALU_PASSB = 3'b000, ALU_ADD = 3'b001, ALU_INCB = 3'b010;

    typedef struct packed {
        logic       wr_rdn;
        logic       enaf;
        logic [2:0] selop;
        logic [1:0] shamt;
        logic       bank_wr_en;
        logic [2:0] busb;
        logic [2:0] busc;
        logic       sclr;
        logic       ir_en;
        logic       mar_en;
        logic       mdr_en;
        logic       mdr_alu_n;
        logic       halted;
        logic       illegal_op;
        logic       bus_err;
        logic       instr_done;
    } ctrl_t;

    typedef struct {
        string      tag;
        logic       run;
        logic       mem_ready;
        logic       z;
        logic [4:0] ir;
        ctrl_t      exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       run = 1'b0;
    logic [4:0] out_IR = '0;
    logic       C = 1'b0, N = 1'b0, P = 1'b0, Z = 1'b0;
    logic       mem_ready = 1'b0;
    logic       wr_rdn, enaf, bank_wr_en, sclr, ir_en, mar_en, mdr_en, mdr_alu_n;
    logic       halted, illegal_op, bus_err, instr_done;
    logic [2:0] selop, BusB_addr, BusC_addr;
    logic [1:0] shamt;
    ctrl_t      act;

    int   vec_count   = 0;
    int   miscompares = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    pdua_control_unit #(
        .MAX_WIDTH(8), .ADDR_WIDTH(3), .OPC_WIDTH(5),
        .PC_ADDR(0), .DPTR_ADDR(2), .ACC_ADDR(7), .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .out_IR(out_IR),
        .C(C), .N(N), .P(P), .Z(Z), .mem_ready(mem_ready),
        .wr_rdn(wr_rdn), .enaf(enaf), .selop(selop), .shamt(shamt),
        .bank_wr_en(bank_wr_en), .BusB_addr(BusB_addr), .BusC_addr(BusC_addr),
        .sclr(sclr), .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en),
        .mdr_alu_n(mdr_alu_n), .halted(halted), .illegal_op(illegal_op),
        .bus_err(bus_err), .instr_done(instr_done)
    );

    assign act = {wr_rdn, enaf, selop, shamt, bank_wr_en, BusB_addr, BusC_addr,
                  sclr, ir_en, mar_en, mdr_en, mdr_alu_n, halted, illegal_op,
                  bus_err, instr_done};

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic rr(input bit run_mid);
        return run_mid ? rbit() : 1'b0;
    endfunction

    task automatic check_output(input string tag, input ctrl_t exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %06h expected %06h", tag, $time, act, exp);
        end
    endtask

    task automatic push(input string tag, input logic r, input logic mr, input logic z,
                        input logic [4:0] ir, input ctrl_t e);
        vec_t v;
        v.tag = tag; v.run = r; v.mem_ready = mr; v.z = z; v.ir = ir; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic add_init();
        ctrl_t e = '0;
        e.sclr = 1'b1;
        push("init", rbit(), rbit(), rbit(), 5'h00, e);
    endtask

    task automatic add_halted(input int n, input logic berr);
        ctrl_t e = '0;
        e.halted  = 1'b1;
        e.bus_err = berr;
        for (int i = 0; i < n; i++) push("halted", rbit(), rbit(), rbit(), 5'h00, e);
    endtask

    // One instruction as a list of cycles: optional pause, 4-phase fetch with wf
    // stall cycles, then the opcode's execute phases with we stall cycles.
    task automatic add_instr(input logic [4:0] opc, input int pause, input int wf,
                             input int we, input logic z, input bit run_mid);
        ctrl_t e;
        for (int i = 0; i < pause; i++) push("pause", 1'b0, rbit(), rbit(), opc, '0);
        e = '0; e.mar_en = 1'b1; e.busb = R_PC; e.selop = ALU_PASSB;
        push("f_mar", 1'b1, rbit(), rbit(), opc, e);
        for (int i = 0; i <= wf; i++) begin
            e = '0; e.mdr_en = 1'b1;
            push("f_mem", rr(run_mid), (i == wf), rbit(), opc, e);
        end
        e = '0; e.ir_en = 1'b1;
        push("f_ir", rr(run_mid), rbit(), rbit(), opc, e);
        e = '0; e.busb = R_PC; e.busc = R_PC; e.selop = ALU_INCB; e.bank_wr_en = 1'b1;
        push("f_pc", rr(run_mid), rbit(), rbit(), opc, e);
        case (opc)
            5'h00: begin
                e = '0; e.instr_done = 1'b1;
                push("nop", rr(run_mid), rbit(), rbit(), opc, e);
            end
            5'h01: begin
                e = '0; e.mar_en = 1'b1; e.busb = R_DPTR;
                push("ld_e1", rr(run_mid), rbit(), rbit(), opc, e);
                for (int i = 0; i <= we; i++) begin
                    e = '0; e.mdr_en = 1'b1;
                    push("ld_e2", rr(run_mid), (i == we), rbit(), opc, e);
                end
                e = '0; e.mdr_alu_n = 1'b1; e.busc = R_ACC; e.bank_wr_en = 1'b1;
                e.instr_done = 1'b1;
                push("ld_e3", rr(run_mid), rbit(), rbit(), opc, e);
            end
            5'h02: begin
                e = '0; e.mar_en = 1'b1; e.busb = R_DPTR;
                push("st_e1", rr(run_mid), rbit(), rbit(), opc, e);
                e = '0; e.mdr_en = 1'b1; e.busb = R_ACC; e.selop = ALU_PASSB;
                push("st_e2", rr(run_mid), rbit(), rbit(), opc, e);
                for (int i = 0; i <= we; i++) begin
                    e = '0; e.wr_rdn = 1'b1; e.instr_done = (i == we);
                    push("st_e3", rr(run_mid), (i == we), rbit(), opc, e);
                end
            end
            5'h03: begin
                e = '0; e.busb = R_DPTR; e.selop = ALU_ADD; e.enaf = 1'b1;
                e.busc = R_ACC; e.bank_wr_en = 1'b1; e.instr_done = 1'b1;
                push("add", rr(run_mid), rbit(), rbit(), opc, e);
            end
            5'h04: begin
                e = '0; e.instr_done = 1'b1;
                if (z) begin
                    e.busb = R_DPTR; e.selop = ALU_PASSB; e.busc = R_PC; e.bank_wr_en = 1'b1;
                end
                push("jz", rr(run_mid), rbit(), z, opc, e);
            end
            5'h1F: push("halt_e1", rr(run_mid), rbit(), rbit(), opc, '0);
            default: begin
                e = '0; e.illegal_op = 1'b1; e.instr_done = 1'b1;
                push("illegal", rr(run_mid), rbit(), rbit(), opc, e);
            end
        endcase
    endtask

    task automatic apply_stimulus();
        vec_t v;
        while (vq.size() > 0) begin
            v = vq.pop_front();
            run = v.run; mem_ready = v.mem_ready; Z = v.z; out_IR = v.ir;
            C = rbit(); N = rbit(); P = rbit();
            #1;
            check_output(v.tag, v.exp);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; run = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check_output("reset", '0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Runs an instruction up to its first E3 cycle, then pulls reset inside it.
    task automatic abort_in_e3(input logic [4:0] opc, input int we, input string tag);
        vec_t v;
        int   n;
        do_reset();
        add_init();
        add_instr(opc, 0, 0, we, 1'b0, 1'b1);
        n = (opc == 5'h02) ? we + 1 : 1;
        for (int i = 0; i < n; i++) v = vq.pop_back();
        apply_stimulus();
        run = v.run; mem_ready = v.mem_ready; Z = v.z; out_IR = v.ir;
        #1;
        check_output({tag, "_e3"}, v.exp);
        #1 rst = 1'b0;
        #1;
        check_output({tag, "_rst"}, '0);
    endtask

    task automatic fetch_timeout();
        ctrl_t e;
        do_reset();
        add_init();
        e = '0; e.mar_en = 1'b1; e.busb = R_PC;
        push("to_f_mar", 1'b1, 1'b0, 1'b0, 5'h00, e);
        for (int i = 0; i < WAIT_MAX; i++) begin
            e = '0; e.mdr_en = 1'b1;
            push("to_f_mem", rbit(), 1'b0, rbit(), 5'h00, e);
        end
        add_halted(4, 1'b1);
        apply_stimulus();
    endtask

    task automatic random_stream(input int count);
        logic [4:0] opc;
        int         wf, we;
        do_reset();
        add_init();
        for (int k = 0; k < count; k++) begin
            case ($urandom_range(0, 5))
                0: opc = 5'h00;
                1: opc = 5'h01;
                2: opc = 5'h02;
                3: opc = 5'h03;
                4: opc = 5'h04;
                default: opc = 5'(5 + $urandom_range(0, 25));
            endcase
            wf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, WAIT_MAX - 1))
                                              : int'($urandom_range(0, 3));
            we = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, WAIT_MAX - 1))
                                              : int'($urandom_range(0, 3));
            add_instr(opc, int'($urandom_range(0, 2)), wf, we, rbit(), 1'b1);
        end
        add_instr(5'h1F, 0, 0, 0, 1'b0, 1'b1);
        add_halted(3, 1'b0);
        apply_stimulus();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        do_reset();
        add_init();
        add_instr(5'h00, 0, 0, 0, 1'b0, 1'b1);
        add_instr(5'h01, 0, 0, 0, 1'b0, 1'b1);
        add_instr(5'h01, 1, 0, 3, 1'b0, 1'b1);
        add_instr(5'h04, 0, 0, 0, 1'b1, 1'b1);
        add_instr(5'h04, 0, 0, 0, 1'b0, 1'b1);
        add_instr(5'h0A, 0, 1, 0, 1'b0, 1'b1);
        add_instr(5'h02, 0, 0, 2, 1'b0, 1'b0);
        add_instr(5'h03, 3, 0, 0, 1'b0, 1'b1);
        add_instr(5'h01, 0, WAIT_MAX - 1, WAIT_MAX - 1, 1'b0, 1'b1);
        add_instr(5'h00, 0, 0, 0, 1'b0, 1'b1);
        add_instr(5'h1F, 0, 0, 0, 1'b0, 1'b1);
        add_halted(3, 1'b0);
        apply_stimulus();

        abort_in_e3(5'h01, 0, "ld_abort");
        abort_in_e3(5'h02, 2, "st_abort");
        fetch_timeout();
        random_stream(60);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
